nonrestoring_div_seq: RTL and testbench

NONRESTORING_DIV_SEQ -- requirements
Module: nonrestoring_div_seq

---
 rtl/nonrestoring_div_seq.sv | 148 ++++++++++++++
 tb/tb_nonrestoring_div_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_div_seq.sv
// Sequential unsigned non-restoring divider: N-bit dividend / M-bit divisor.
// One quotient bit per RUN cycle, a single FIX cycle for the final remainder
// correction, then the result is held in DONE until the consumer takes it.
module nonrestoring_div_seq #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    localparam int unsigned PW = M + 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [N-1:0]    a_q;
    logic [PW-1:0]   p_q;
    logic [PW-1:0]   d_q;
    logic [CW-1:0]   cnt_q;

    logic            accept_c;
    logic            last_iter_c;
    logic [PW-1:0]   p_shift_c;
    logic [PW-1:0]   p_step_c;
    logic [N-1:0]    a_step_c;
    logic [PW-1:0]   p_fix_c;

    // One non-restoring step and the final correction, from current registers.
    always_comb begin
        p_shift_c   = {p_q[M-1:0], a_q[N-1]};
        p_step_c    = p_q[M] ? (p_shift_c + d_q) : (p_shift_c - d_q);
        a_step_c    = {a_q[N-2:0], ~p_step_c[M]};
        p_fix_c     = p_q[M] ? (p_q + d_q) : p_q;
        last_iter_c = (cnt_q == CW'(N - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; operands are only looked at in IDLE, out_ready only in DONE.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter_c) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            p_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
            busy      <= (state_d != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        a_q         <= dividend;
                        d_q         <= {1'b0, divisor};
                        p_q         <= '0;
                        cnt_q       <= '0;
                        div_by_zero <= (divisor == '0);
                    end
                end
                S_RUN: begin
                    a_q <= a_step_c;
                    p_q <= p_step_c;
                    if (!last_iter_c) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    p_q <= p_fix_c;
                    // A zero divisor leaves garbage in A/P, so the result is forced.
                    if (div_by_zero) begin
                        quotient  <= '1;
                        remainder <= '0;
                    end else begin
                        quotient  <= a_q;
                        remainder <= p_fix_c[M-1:0];
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_div_seq.sv
// Self-checking bench for nonrestoring_div_seq (N = 8, M = 4).
module tb_nonrestoring_div_seq;

    localparam int unsigned N   = 8;
    localparam int unsigned M   = 4;
    localparam int          LAT = N + 2;
    localparam int          NV  = 11;
    localparam int          NRAND = 4000;

    typedef struct {
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         z;
    } exp_t;

    typedef struct {
        logic [N-1:0] dd;
        logic [M-1:0] dv;
        int           hold;
        exp_t         e;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t tbl[NV];

    nonrestoring_div_seq #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] dd, input logic [M-1:0] dv);
        exp_t e;
        if (dv == '0) begin
            e.q = '1;
            e.r = '0;
            e.z = 1'b1;
        end else begin
            e.q = N'(int'(dd) / int'(dv));
            e.r = M'(int'(dd) % int'(dv));
            e.z = 1'b0;
        end
        return e;
    endfunction

    function automatic vec_t mk(input int dd, input int dv, input int hold,
                                input int q, input int r, input int z);
        vec_t v;
        v.dd   = N'(dd);
        v.dv   = M'(dv);
        v.hold = hold;
        v.e.q  = N'(q);
        v.e.r  = M'(r);
        v.e.z  = 1'(z);
        return v;
    endfunction

    // Entered and left just after a falling edge with the DUT in IDLE.
    task automatic run_op(input logic [N-1:0] dd, input logic [M-1:0] dv,
                          input int hold, input exp_t e);
        exp_t got;
        int   lat;
        logic [N-1:0] q0;
        logic [M-1:0] r0;
        dividend  = dd;
        divisor   = dv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        sb.push_back(e);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        chk("dbz_at_accept", 32'(div_by_zero), 32'(e.z));
        while (!out_valid && lat < LAT + 8) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            dividend  = N'($urandom);
            divisor   = M'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        chk("latency", 32'(lat), 32'(LAT));
        got = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(got.q));
        chk("remainder", 32'(remainder), 32'(got.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(got.z));
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_quotient", 32'(quotient), 32'(q0));
            chk("hold_remainder", 32'(remainder), 32'(r0));
            chk("hold_dbz", 32'(div_by_zero), 32'(got.z));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("consumed_valid", 32'(out_valid), 32'd0);
        chk("consumed_in_ready", 32'(in_ready), 32'd1);
        chk("consumed_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] rdd;
        logic [M-1:0] rdv;
        exp_t         e;
        checks = 0;
        errors = 0;

        tbl[0]  = mk(100,  7, 0,  14,  2, 0);
        tbl[1]  = mk(255,  1, 0, 255,  0, 0);
        tbl[2]  = mk(  5,  9, 0,   0,  5, 0);
        tbl[3]  = mk(200,  0, 0, 255,  0, 1);
        tbl[4]  = mk( 77, 15, 6,   5,  2, 0);
        tbl[5]  = mk(  0,  5, 0,   0,  0, 0);
        tbl[6]  = mk(255, 15, 2,  17,  0, 0);
        tbl[7]  = mk(255,  2, 0, 127,  1, 0);
        tbl[8]  = mk(  0,  0, 1, 255,  0, 1);
        tbl[9]  = mk( 14, 15, 0,   0, 14, 0);
        tbl[10] = mk(128,  3, 0,  42,  2, 0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        // Directed vectors; consecutive entries run back-to-back.
        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].dd, tbl[i].dv, tbl[i].hold, tbl[i].e);
        end

        // Reset while RUN is at iteration 4 of 100 / 7.
        dividend = 8'd100;
        divisor  = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        e.q = 8'd3;
        e.r = 4'd0;
        e.z = 1'b0;
        run_op(8'd9, 4'd3, 0, e);

        // Random operand pairs against the arithmetic model.
        for (int k = 0; k < NRAND; k++) begin
            rdd = N'($urandom);
            rdv = M'($urandom);
            run_op(rdd, rdv, int'($urandom_range(0, 1)), model(rdd, rdv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
